// File: rtl/line_window_ctrl.sv
// line_window_ctrl: raster sequencer gating row-buffer shifts and flagging kernel windows, line/frame ends
//   in : clk, rst_n (async active-low), frame_start, pixel_valid
//   out: shift_en (comb accept), col/row (position of next pixel), window_valid, line_done,
//        frame_done (registered pulses), busy (not IDLE), proto_err (sticky, pixel while IDLE)
module line_window_ctrl #(
  parameter int ROW_SIZE = 1280,
  parameter int NUM_ROWS = 960,
  parameter int KERNEL = 3,
  localparam int COL_W = $clog2(ROW_SIZE),
  localparam int ROW_W = $clog2(NUM_ROWS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic pixel_valid,
  output logic shift_en,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic window_valid,
  output logic line_done,
  output logic frame_done,
  output logic busy,
  output logic proto_err
);
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0] COL_K = COL_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] ROW_K = ROW_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] ROW_FILL = ROW_W'(KERNEL - 2);
  state_t state, state_nxt;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic wv_nxt, ld_nxt, fd_nxt, pe_nxt, acc, run, last_col, last_row;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      window_valid <= 1'b0;
      line_done <= 1'b0;
      frame_done <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      col <= col_nxt;
      row <= row_nxt;
      window_valid <= wv_nxt;
      line_done <= ld_nxt;
      frame_done <= fd_nxt;
      proto_err <= pe_nxt;
    end
  end
  // run: an accepted pixel that continues the current frame; a frame_start pixel is always (0,0)
  always_comb begin
    acc = pixel_valid & (state != IDLE | frame_start);
    run = acc & ~frame_start;
    last_col = col == COL_LAST;
    last_row = row == ROW_LAST;
    state_nxt = frame_start ? FILL :
                run & last_col & state == FILL & row == ROW_FILL ? STREAM :
                run & last_col & state == STREAM & last_row ? IDLE : state;
    col_nxt = frame_start ? COL_W'(pixel_valid) : run ? (last_col ? '0 : col + COL_W'(1)) : col;
    row_nxt = frame_start ? '0 : run & last_col ? (last_row ? '0 : row + ROW_W'(1)) : row;
    wv_nxt = run & row >= ROW_K & col >= COL_K;
    ld_nxt = run & last_col;
    fd_nxt = run & last_col & last_row & state == STREAM;
    pe_nxt = ~frame_start & (proto_err | pixel_valid & state == IDLE);
  end
  always_comb begin
    shift_en = pixel_valid & (state != IDLE | frame_start);
    busy = state != IDLE;
  end
endmodule

// File: doc/line_window_ctrl.md
# line_window_ctrl

Sequencing controller for the row-buffer line-delay chain that feeds the 3x3 (KERNEL x KERNEL) convolution datapath. It tracks the raster position of each incoming pixel and gates the row-buffer shift enable. It reports when the buffered rows hold a complete kernel window, and flags line and frame boundaries plus protocol errors. It sits between the camera/capture pixel stream and the row buffers plus convolution engine.

## Interface
- ROW_SIZE, 1280, pixels per row (≥ KERNEL)
- NUM_ROWS, 960, rows per frame (≥ KERNEL)
- KERNEL, 3, window height and width (≥ 2)
- COL_W = $clog2(ROW_SIZE), ROW_W = $clog2(NUM_ROWS), derived localparams

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  single-cycle start-of-frame strobe
- pixel_valid  in  1  input pixel present this cycle
- shift_en  out  1  combinational; advance row buffers / accept pixel
- col  out  COL_W  column the next accepted pixel will occupy
- row  out  ROW_W  row the next accepted pixel will occupy
- window_valid  out  1  registered; a full KERNEL x KERNEL window is present
- line_done  out  1  registered one-cycle pulse after the last pixel of a row
- frame_done  out  1  registered one-cycle pulse after the last pixel of a frame
- busy  out  1  state != IDLE
- proto_err  out  1  sticky; pixel_valid arrived while IDLE

## Operation
- States: IDLE, FILL (first KERNEL-1 rows), STREAM (remaining rows).
- Accept condition: acc = pixel_valid & (state != IDLE | frame_start). shift_en = acc.
- frame_start, in any state:
  - col and row are cleared to 0, the next state is FILL, and proto_err is cleared.
  - If pixel_valid is high in the same cycle, that pixel is accepted as (0,0) and col becomes 1.
  - frame_start takes priority over all other transitions.
- On acc, col increments. When col == ROW_SIZE-1, col wraps to 0, row increments, and line_done pulses the next cycle.
- FILL -> STREAM on acc at col == ROW_SIZE-1, row == KERNEL-2.
- STREAM -> IDLE on acc at col == ROW_SIZE-1, row == NUM_ROWS-1. On this transition:
  - row and col return to 0.
  - frame_done and line_done both pulse the next cycle.
- window_valid is registered as acc & (row ≥ KERNEL-1) & (col ≥ KERNEL-1), evaluated on the pre-increment counters.
- pixel_valid in IDLE without frame_start: the pixel is not accepted, shift_en stays 0, and proto_err is set.
- No pixel_valid: counters, state and outputs hold, and all pulses deassert.
- Arithmetic: counters are unsigned and compared against parameter constants. There is no saturation; wrap is explicit as described above.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, col = 0, row = 0.
  - window_valid, line_done, frame_done, busy and proto_err are all 0.
  - shift_en = 0, since it depends on state, which is IDLE.
- shift_en has zero-cycle latency from pixel_valid. The row buffers shift on the same edge that advances the counters.
- window_valid, line_done and frame_done assert exactly 1 cycle after the accepting edge's cycle. They are aligned with the row-buffer outputs updated on that edge.
- busy rises the cycle after frame_start and falls the cycle after the final accepted pixel (the same cycle frame_done is high).
- Per frame with continuous valid:
  - ROW_SIZE*NUM_ROWS accepts.
  - (ROW_SIZE-KERNEL+1)*(NUM_ROWS-KERNEL+1) window_valid pulses.
  - NUM_ROWS line_done pulses.
  - 1 frame_done pulse.
- Reset asserted mid-frame aborts immediately. No frame_done is emitted, and the next frame requires frame_start.

## Test plan
Benches use ROW_SIZE=8, NUM_ROWS=4, KERNEL=3.

- **Reset values:** assert rst_n low asynchronously mid-cycle -> all outputs 0 immediately; state is IDLE.
- **Continuous frame:** frame_start with valid, then 31 more valid cycles -> 32 shift_en, 12 window_valid (first one the cycle after pixel (2,2), i.e. the 19th accept), 4 line_done, a single frame_done the cycle after the 32nd accept, and busy low from that cycle.
- **Gapped stream:** pixel_valid toggling 1/0 -> counters advance only on valid, still exactly 12 window_valid and 1 frame_done, and no pulses on idle cycles.
- **Restart:** frame_start together with pixel_valid at accept #13 (row 1, col 4) -> col=1, row=0, state FILL, no frame_done; the frame then completes normally after 31 further accepts.
- **Protocol error:** pixel_valid for 3 cycles while IDLE -> shift_en stays 0 and proto_err=1 and stays set; frame_start clears it the next cycle.
- **Reset mid-STREAM:** drop rst_n at row 2, col 5 -> everything returns to 0 and no frame_done is emitted; the following pixel_valid without frame_start sets proto_err.
